// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 power sequencer: step-word op codes,
// pin select codes, program start addresses, ROM word layout and FSM states.
package oled_pkg;

    // Step word is {op[1:0], arg[7:0]}.
    typedef enum logic [1:0] {
        OP_SEND  = 2'd0,
        OP_DELAY = 2'd1,
        OP_PIN   = 2'd2,
        OP_END   = 2'd3
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [7:0] arg;
    } step_t;

    // arg[1:0] of a PIN step selects the pin; arg[7] is the level driven.
    localparam logic [1:0] PIN_VDD  = 2'd0;
    localparam logic [1:0] PIN_VBAT = 2'd1;
    localparam logic [1:0] PIN_RES  = 2'd2;

    localparam int              PC_W          = 5;
    localparam logic [PC_W-1:0] PC_UP_START   = 5'd0;
    localparam logic [PC_W-1:0] PC_DOWN_START = 5'd24;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_FETCH,
        ST_SEND,
        ST_WAIT_SPI,
        ST_DELAY,
        ST_WAIT_DLY,
        ST_PIN,
        ST_ON
    } state_t;

    function automatic step_t mk_send(logic [7:0] cmd);
        return '{op: OP_SEND, arg: cmd};
    endfunction

    function automatic step_t mk_delay(logic [7:0] ms);
        return '{op: OP_DELAY, arg: ms};
    endfunction

    // Supplies and reset are active-low: level 0 means "on" for VDD/VBAT.
    function automatic step_t mk_pin(logic [1:0] sel, logic level);
        return '{op: OP_PIN, arg: {level, 5'b0, sel}};
    endfunction

    function automatic step_t mk_end();
        return '{op: OP_END, arg: 8'h00};
    endfunction

endpackage

// File: rtl/oled_seq_rom.sv
// Combinational program ROM for the OLED power sequencer.
// Power-up program at 0..20; power-down program at 24..28 exists only when
// OLED_POWERDOWN_EN is defined. Every unused address reads END so the
// sequencer can never run off the end of a program.
module oled_seq_rom
    import oled_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    output step_t           step
);

    // Address decode of the fixed power-up / power-down programs.
    // NOTE: the ROM is pure combinational decode; there is no storage to reset.
    always_comb begin
        step = mk_end();
        case (pc)
            5'd0:  step = mk_pin(PIN_VDD, 1'b0);
            5'd1:  step = mk_delay(8'd1);
            5'd2:  step = mk_send(8'hAE);
            5'd3:  step = mk_pin(PIN_RES, 1'b0);
            5'd4:  step = mk_delay(8'd1);
            5'd5:  step = mk_pin(PIN_RES, 1'b1);
            5'd6:  step = mk_delay(8'd1);
            5'd7:  step = mk_send(8'h8D);
            5'd8:  step = mk_send(8'h14);
            5'd9:  step = mk_send(8'hD9);
            5'd10: step = mk_send(8'hF1);
            5'd11: step = mk_pin(PIN_VBAT, 1'b0);
            5'd12: step = mk_delay(8'd100);
            5'd13: step = mk_send(8'h81);
            5'd14: step = mk_send(8'h0F);
            5'd15: step = mk_send(8'hA1);
            5'd16: step = mk_send(8'hC8);
            5'd17: step = mk_send(8'hDA);
            5'd18: step = mk_send(8'h20);
            5'd19: step = mk_send(8'hAF);
            5'd20: step = mk_end();
`ifdef OLED_POWERDOWN_EN
            5'd24: step = mk_send(8'hAE);
            5'd25: step = mk_pin(PIN_VBAT, 1'b1);
            5'd26: step = mk_delay(8'd100);
            5'd27: step = mk_pin(PIN_VDD, 1'b1);
            5'd28: step = mk_end();
`endif
            default: step = mk_end();
        endcase
    end

endmodule

// File: rtl/oled_power_seq.sv
// SSD1306 power-up / power-down sequencer.
// Walks the step ROM, drives the supply/reset pins, hands command bytes to
// the SPI sender and waits on the millisecond delay unit. Optional feature
// macro OLED_POWERDOWN_EN compiles in the power-down program and power_off
// handling; without it ON is terminal until rst.
module oled_power_seq
    import oled_pkg::*;
#(
    parameter int DLY_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power_on,
    input  logic             power_off,
    output logic             ready,
    output logic             busy,
    output logic             oled_vdd_n,
    output logic             oled_vbat_n,
    output logic             oled_res_n,
    output logic             oled_dc,
    output logic             spi_send,
    output logic [7:0]       spi_data,
    input  logic             spi_done,
    output logic             delay_start,
    output logic [DLY_W-1:0] delay_time_ms,
    input  logic             delay_done
);

    state_t          state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    step_t           rom_step;
    logic [1:0]      pin_sel;
    logic            pin_level;
    logic            in_seq;

    assign in_seq = (state != ST_OFF) && (state != ST_ON);

    oled_seq_rom u_rom (
        .pc   (pc),
        .step (rom_step)
    );

`ifdef OLED_POWERDOWN_EN
    logic off_pending, off_next;
    logic in_down;

    assign in_down = (pc >= PC_DOWN_START);
`else
    logic unused_power_off;

    assign unused_power_off = power_off;
`endif

    // State, program counter and latched power-off request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            pc    <= PC_UP_START;
`ifdef OLED_POWERDOWN_EN
            off_pending <= 1'b0;
`endif
        end else begin
            state <= state_next;
            pc    <= pc_next;
`ifdef OLED_POWERDOWN_EN
            off_pending <= off_next;
`endif
        end
    end

    // Next-state, next-pc and power-off latch decisions.
    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
`ifdef OLED_POWERDOWN_EN
        off_next = off_pending;
        // A power-off during power-up (or together with power-on) is held
        // until the up program reaches END.
        if (power_off && ((state == ST_OFF && power_on) || (in_seq && !in_down)))
            off_next = 1'b1;
`endif
        case (state)
            ST_OFF: begin
                if (power_on) begin
                    state_next = ST_FETCH;
                    pc_next    = PC_UP_START;
                end
            end
            ST_FETCH: begin
                case (rom_step.op)
                    OP_SEND:  state_next = ST_SEND;
                    OP_DELAY: state_next = ST_DELAY;
                    OP_PIN:   state_next = ST_PIN;
                    OP_END: begin
`ifdef OLED_POWERDOWN_EN
                        if (in_down) begin
                            state_next = ST_OFF;
                        end else if (off_next) begin
                            state_next = ST_FETCH;
                            pc_next    = PC_DOWN_START;
                            off_next   = 1'b0;
                        end else begin
                            state_next = ST_ON;
                        end
`else
                        state_next = ST_ON;
`endif
                    end
                    default: state_next = ST_OFF;
                endcase
            end
            ST_SEND:  state_next = ST_WAIT_SPI;
            ST_WAIT_SPI: begin
                if (spi_done) begin
                    state_next = ST_FETCH;
                    pc_next    = pc + 5'd1;
                end
            end
            ST_DELAY: state_next = ST_WAIT_DLY;
            ST_WAIT_DLY: begin
                if (delay_done) begin
                    state_next = ST_FETCH;
                    pc_next    = pc + 5'd1;
                end
            end
            ST_PIN: begin
                state_next = ST_FETCH;
                pc_next    = pc + 5'd1;
            end
            ST_ON: begin
`ifdef OLED_POWERDOWN_EN
                if (power_off) begin
                    state_next = ST_FETCH;
                    pc_next    = PC_DOWN_START;
                end
`endif
            end
            default: state_next = ST_OFF;
        endcase
    end

    // Registered outputs: request pulses and operands are loaded in FETCH so
    // they are visible during the SEND/DELAY cycle; pins update in PIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            oled_vdd_n    <= 1'b1;
            oled_vbat_n   <= 1'b1;
            oled_res_n    <= 1'b1;
            oled_dc       <= 1'b0;
            spi_send      <= 1'b0;
            spi_data      <= 8'h00;
            delay_start   <= 1'b0;
            delay_time_ms <= '0;
            ready         <= 1'b0;
            busy          <= 1'b0;
            pin_sel       <= 2'd0;
            pin_level     <= 1'b1;
        end else begin
            oled_dc     <= 1'b0;
            spi_send    <= 1'b0;
            delay_start <= 1'b0;
            if (state == ST_FETCH) begin
                pin_sel   <= rom_step.arg[1:0];
                pin_level <= rom_step.arg[7];
                if (rom_step.op == OP_SEND) begin
                    spi_send <= 1'b1;
                    spi_data <= rom_step.arg;
                end
                if (rom_step.op == OP_DELAY) begin
                    delay_start   <= 1'b1;
                    delay_time_ms <= DLY_W'(rom_step.arg);
                end
            end
            if (state == ST_PIN) begin
                case (pin_sel)
                    PIN_VDD:  oled_vdd_n  <= pin_level;
                    PIN_VBAT: oled_vbat_n <= pin_level;
                    PIN_RES:  oled_res_n  <= pin_level;
                    default:  ;
                endcase
            end
            ready <= (state_next == ST_ON);
            busy  <= (state_next != ST_OFF) && (state_next != ST_ON);
        end
    end

endmodule

// File: tb/tb_oled_power_seq.sv
// Self-checking bench for oled_power_seq. SPI partner drops done for 16
// cycles per request; delay partner drops done for ms*10 cycles. Observed
// pin edges, bytes and delay requests are logged as events and compared with
// the event order the power programs describe.
module tb_oled_power_seq;

    localparam int DLY_W = 12;

    localparam int K_SEND = 1;
    localparam int K_DLY  = 2;
    localparam int K_VDD  = 3;
    localparam int K_VBAT = 4;
    localparam int K_RES  = 5;

    // vdd_n,vbat_n,res_n,dc,spi_send,spi_data,delay_start,delay_time_ms,ready,busy
    localparam logic [27:0] RST_VEC = {4'b1110, 1'b0, 8'h00, 1'b0, 12'h000, 2'b00};

    typedef logic [15:0] ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             power_on;
    logic             power_off;
    logic             ready;
    logic             busy;
    logic             oled_vdd_n;
    logic             oled_vbat_n;
    logic             oled_res_n;
    logic             oled_dc;
    logic             spi_send;
    logic [7:0]       spi_data;
    logic             spi_done;
    logic             delay_start;
    logic [DLY_W-1:0] delay_time_ms;
    logic             delay_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    oled_power_seq #(.DLY_W(DLY_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .power_on      (power_on),
        .power_off     (power_off),
        .ready         (ready),
        .busy          (busy),
        .oled_vdd_n    (oled_vdd_n),
        .oled_vbat_n   (oled_vbat_n),
        .oled_res_n    (oled_res_n),
        .oled_dc       (oled_dc),
        .spi_send      (spi_send),
        .spi_data      (spi_data),
        .spi_done      (spi_done),
        .delay_start   (delay_start),
        .delay_time_ms (delay_time_ms),
        .delay_done    (delay_done)
    );

    // Handshake partners.
    int spi_cnt;
    int dly_cnt;

    always @(posedge clk) begin
        if (rst)               spi_cnt <= 0;
        else if (spi_send)     spi_cnt <= 16;
        else if (spi_cnt > 0)  spi_cnt <= spi_cnt - 1;
    end
    assign spi_done = (spi_cnt == 0);

    always @(posedge clk) begin
        if (rst)               dly_cnt <= 0;
        else if (delay_start)  dly_cnt <= int'(delay_time_ms) * 10;
        else if (dly_cnt > 0)  dly_cnt <= dly_cnt - 1;
    end
    assign delay_done = (dly_cnt == 0);

    function automatic ev_t mk_ev(int k, int v);
        return ev_t'((k << 12) | (v & 12'hFFF));
    endfunction

    function automatic logic [27:0] out_vec();
        return {oled_vdd_n, oled_vbat_n, oled_res_n, oled_dc, spi_send, spi_data,
                delay_start, delay_time_ms, ready, busy};
    endfunction

    // Event monitor, sampled on the falling edge.
    ev_t  ev_log[$];
    ev_t  exp_q[$];
    int   ready_cnt = 0;
    logic p_vdd = 1'b1, p_vbat = 1'b1, p_res = 1'b1;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (spi_send)             ev_log.push_back(mk_ev(K_SEND, int'(spi_data)));
            if (delay_start)          ev_log.push_back(mk_ev(K_DLY, int'(delay_time_ms)));
            if (oled_vdd_n !== p_vdd)   ev_log.push_back(mk_ev(K_VDD, int'(oled_vdd_n)));
            if (oled_vbat_n !== p_vbat) ev_log.push_back(mk_ev(K_VBAT, int'(oled_vbat_n)));
            if (oled_res_n !== p_res)   ev_log.push_back(mk_ev(K_RES, int'(oled_res_n)));
            if (ready)                ready_cnt <= ready_cnt + 1;
        end
        p_vdd  <= oled_vdd_n;
        p_vbat <= oled_vbat_n;
        p_res  <= oled_res_n;
    end

    // Reference model: the event order of each program.
    task automatic add_up();
        logic [7:0] cfg1 [4] = '{8'h8D, 8'h14, 8'hD9, 8'hF1};
        logic [7:0] cfg2 [7] = '{8'h81, 8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
        exp_q.push_back(mk_ev(K_VDD, 0));
        exp_q.push_back(mk_ev(K_DLY, 1));
        exp_q.push_back(mk_ev(K_SEND, 'hAE));
        exp_q.push_back(mk_ev(K_RES, 0));
        exp_q.push_back(mk_ev(K_DLY, 1));
        exp_q.push_back(mk_ev(K_RES, 1));
        exp_q.push_back(mk_ev(K_DLY, 1));
        foreach (cfg1[i]) exp_q.push_back(mk_ev(K_SEND, int'(cfg1[i])));
        exp_q.push_back(mk_ev(K_VBAT, 0));
        exp_q.push_back(mk_ev(K_DLY, 100));
        foreach (cfg2[i]) exp_q.push_back(mk_ev(K_SEND, int'(cfg2[i])));
    endtask

    task automatic add_down();
        exp_q.push_back(mk_ev(K_SEND, 'hAE));
        exp_q.push_back(mk_ev(K_VBAT, 1));
        exp_q.push_back(mk_ev(K_DLY, 100));
        exp_q.push_back(mk_ev(K_VDD, 1));
    endtask

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_on();
        power_on = 1'b1;
        tick(1);
        power_on = 1'b0;
    endtask

    task automatic pulse_off();
        power_off = 1'b1;
        tick(1);
        power_off = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(output bit ok);
        int c = 0;
        while (busy && c < 8000) begin
            tick(1);
            c++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        power_on  = 1'b0;
        power_off = 1'b0;
        rst       = 1'b1;
        tick(3);
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_values: got %h expected %h", out_vec(), RST_VEC);
        end
        rst = 1'b0;
        tick(4);
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h expected %h", out_vec(), RST_VEC);
        end
    endtask

    task automatic test_power_up();
        int base;
        bit ok;
        tick($urandom_range(1, 20));
        base = ev_log.size();
        exp_q.delete();
        add_up();
        pulse_on();
        n_cmp++;
        if ({busy, ready, oled_vdd_n} !== 3'b101) begin
            n_bad++;
            $display("FAIL busy_after_1: got busy,ready,vdd_n=%b expected 101", {busy, ready, oled_vdd_n});
        end
        tick(1);
        n_cmp++;
        if (oled_vdd_n !== 1'b1) begin
            n_bad++;
            $display("FAIL vdd_early: got %b expected 1", oled_vdd_n);
        end
        tick(1);
        n_cmp++;
        if (oled_vdd_n !== 1'b0) begin
            n_bad++;
            $display("FAIL vdd_at_3: got %b expected 0", oled_vdd_n);
        end
        wait_idle(ok);
        n_cmp++;
        if ({ok, ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL up_done: got ok,ready,busy=%b expected 110", {ok, ready, busy});
        end
        n_cmp++;
        if (ev_log.size() - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL up_event_count: got %0d expected %0d", ev_log.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t got = (base + i < ev_log.size()) ? ev_log[base + i] : 16'hFFFF;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++;
                $display("FAIL up_event[%0d]: got %h expected %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_on_ignored();
        int base = ev_log.size();
        pulse_on();
        tick(40);
        n_cmp++;
        if ({ev_log.size() - base, ready, busy} !== {32'd0, 2'b10}) begin
            n_bad++;
            $display("FAIL on_in_on: got events=%0d ready=%b busy=%b expected 0 1 0",
                     ev_log.size() - base, ready, busy);
        end
    endtask

    task automatic test_power_down();
        int base = ev_log.size();
        bit ok;
        exp_q.delete();
`ifdef OLED_POWERDOWN_EN
        add_down();
`endif
        pulse_off();
`ifdef OLED_POWERDOWN_EN
        wait_idle(ok);
        n_cmp++;
        if ({ok, ready, busy, oled_vdd_n, oled_vbat_n} !== 5'b10011) begin
            n_bad++;
            $display("FAIL down_done: got ok,ready,busy,vdd_n,vbat_n=%b expected 10011",
                     {ok, ready, busy, oled_vdd_n, oled_vbat_n});
        end
`else
        ok = 1'b1;
        tick(60);
        n_cmp++;
        if ({ok, ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL off_ignored_in_on: got ok,ready,busy=%b expected 110", {ok, ready, busy});
        end
`endif
        n_cmp++;
        if (ev_log.size() - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL down_event_count: got %0d expected %0d", ev_log.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t got = (base + i < ev_log.size()) ? ev_log[base + i] : 16'hFFFF;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++;
                $display("FAIL down_event[%0d]: got %h expected %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_off_in_off();
        int base;
        do_reset();
        base = ev_log.size();
        pulse_off();
        tick(30);
        n_cmp++;
        if ({ev_log.size() - base, ready, busy} !== {32'd0, 2'b00}) begin
            n_bad++;
            $display("FAIL off_in_off: got events=%0d ready=%b busy=%b expected 0 0 0",
                     ev_log.size() - base, ready, busy);
        end
    endtask

    // mode 0: power_off at step 12 (100 ms request); 1: random time during
    // power-up; 2: power_on and power_off in the same cycle.
    task automatic test_off_in_up(int mode);
        int base, rbase, c;
        bit ok;
        do_reset();
        base  = ev_log.size();
        rbase = ready_cnt;
        exp_q.delete();
        add_up();
`ifdef OLED_POWERDOWN_EN
        add_down();
`endif
        if (mode == 2) begin
            power_on  = 1'b1;
            power_off = 1'b1;
            tick(1);
            power_on  = 1'b0;
            power_off = 1'b0;
        end else begin
            pulse_on();
            if (mode == 0) begin
                c = 0;
                while (!(delay_start && delay_time_ms == 12'd100) && c < 3000) begin
                    tick(1);
                    c++;
                end
                n_cmp++;
                if (c >= 3000) begin
                    n_bad++;
                    $display("FAIL step12_reach: got timeout expected delay_start 100");
                end
            end else begin
                tick($urandom_range(2, 1150));
            end
            pulse_off();
        end
        wait_idle(ok);
`ifdef OLED_POWERDOWN_EN
        n_cmp++;
        if ({ok, ready, busy, ready_cnt - rbase} !== {3'b100, 32'd0}) begin
            n_bad++;
            $display("FAIL off_up_m%0d_done: got ok=%b ready=%b busy=%b ready_cycles=%0d expected 1 0 0 0",
                     mode, ok, ready, busy, ready_cnt - rbase);
        end
`else
        n_cmp++;
        if ({ok, ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL off_up_m%0d_done: got ok,ready,busy=%b expected 110", mode, {ok, ready, busy});
        end
`endif
        n_cmp++;
        if (ev_log.size() - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL off_up_m%0d_count: got %0d expected %0d", mode, ev_log.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t got = (base + i < ev_log.size()) ? ev_log[base + i] : 16'hFFFF;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++;
                $display("FAIL off_up_m%0d_event[%0d]: got %h expected %h", mode, i, got, exp_q[i]);
            end
        end
    endtask

    // Reset inside WAIT_DLY, then a restart with spurious power_on pulses.
    task automatic test_reset_mid();
        int base, c;
        bit ok;
        do_reset();
        pulse_on();
        c = 0;
        while (!delay_start && c < 200) begin
            tick(1);
            c++;
        end
        tick(3);
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if (out_vec() !== RST_VEC) begin
            n_bad++;
            $display("FAIL reset_mid: got %h expected %h", out_vec(), RST_VEC);
        end
        rst = 1'b0;
        tick(5);
        base = ev_log.size();
        exp_q.delete();
        add_up();
        pulse_on();
        for (int k = 0; k < 3; k++) begin
            tick($urandom_range(5, 300));
            pulse_on();
        end
        wait_idle(ok);
        n_cmp++;
        if ({ok, ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL restart_done: got ok,ready,busy=%b expected 110", {ok, ready, busy});
        end
        n_cmp++;
        if (ev_log.size() - base != exp_q.size()) begin
            n_bad++;
            $display("FAIL restart_count: got %0d expected %0d", ev_log.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t got = (base + i < ev_log.size()) ? ev_log[base + i] : 16'hFFFF;
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++;
                $display("FAIL restart_event[%0d]: got %h expected %h", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_on_ignored();
        test_power_down();
        test_off_in_off();
        test_off_in_up(0);
        test_off_in_up(1);
        test_off_in_up(2);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
